// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU-side memory bus master.
// Latency: combinational helpers only.
// Backpressure: none (no handshakes in this file).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    RDATA = 2'b10,
    RESP  = 2'b11
  } state_t;

  // Little-endian lane enables for an access of the given size at a byte offset.
  function automatic logic [3:0] be_for(size_t size, logic [1:0] offset);
    case (size)
      BYTE:    return 4'b0001 << offset;
      HALF:    return offset[1] ? 4'b1100 : 4'b0011;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // True for requests that must be rejected without a bus cycle
  // (illegal size, or an offset not naturally aligned for the size).
  function automatic logic misaligned(size_t size, logic [1:0] offset);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return offset[0];
      WORD:    return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_load_align.sv
// Picks the addressed lane(s) out of a bus word and sign/zero-extends them.
// Latency: purely combinational.
// Backpressure: none.
module load_align
  import mem_bus_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select by byte offset, then extend to 32 bits.
  always_comb begin
    lane_b = readdata[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? readdata[31:16] : readdata[15:0];
    case (size)
      BYTE:    result = {{24{is_signed & lane_b[7]}}, lane_b};
      HALF:    result = {{16{is_signed & lane_h[15]}}, lane_h};
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// One-at-a-time load/store initiator for the word-wide memory bus.
// Latency: store 2, load 3, reject 1 cycles after handshake, +1 per wait state.
// Backpressure: req_ready only in IDLE; bus strobes held while waitrequest is high.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_t      state;
  logic        r_write;
  size_t       r_size;
  logic        r_signed;
  logic [1:0]  r_offset;
  logic [31:0] to_cnt;
  logic [31:0] load_result;
  size_t       in_size;

  assign in_size   = size_t'(req_size);
  assign req_ready = (state == IDLE);

  // Stores replicate the right-aligned data across every lane it could land on.
  function automatic logic [31:0] rep_wdata(size_t sz, logic [31:0] d);
    case (sz)
      BYTE:    return {4{d[7:0]}};
      HALF:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  load_align u_load_align (
    .readdata  (readdata),
    .offset    (r_offset),
    .size      (r_size),
    .is_signed (r_signed),
    .result    (load_result)
  );

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      r_write    <= 1'b0;
      r_size     <= BYTE;
      r_signed   <= 1'b0;
      r_offset   <= 2'b00;
      to_cnt     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= in_size;
            r_signed <= req_signed;
            r_offset <= req_addr[1:0];
            if (misaligned(in_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= BUS;
              read       <= ~req_write;
              write      <= req_write;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= be_for(in_size, req_addr[1:0]);
              writedata  <= rep_wdata(in_size, req_wdata);
              to_cnt     <= '0;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            if (r_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end else begin
              state <= RDATA;
            end
          end else if (TIMEOUT_CYCLES != 32'd0 && to_cnt + 32'd1 == TIMEOUT_CYCLES) begin
            // Slave never accepted: abandon the cycle and report an error.
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        RDATA: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_result;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios plus random traffic.
// Latency: checks response cycle against handshake edge for every transaction.
// Backpressure: bench slave injects wait states and a stuck waitrequest.
module tb_mem_bus_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  always #5 clk = ~clk;

  mem_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Bus slave storage (written by the DUT's bus cycles) and the reference byte memory.
  logic [31:0] slv_mem [0:63];
  logic [7:0]  ref_mem [0:255];

  // Observations of the most recent transaction.
  int          o_lat, o_strobes;
  logic        o_err, o_rd, o_wr, o_ready_at_resp, o_idle_dirty, o_unstable;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) slv_mem[i] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  // Issue one request and act as the bus slave until the response pulse (bounded).
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int nwait, input logic stuck);
    int   waits_left;
    logic rd_phase, rd_next;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    o_lat = -1; o_strobes = 0; o_err = 1'bx; o_rdata = 'x; o_ready_at_resp = 1'bx;
    o_idle_dirty = 1'b0; o_unstable = 1'b0;
    o_rd = 1'b0; o_wr = 1'b0; o_be = '0; o_addr = '0; o_wd = '0;
    waits_left = nwait; rd_next = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rd_phase = rd_next; rd_next = 1'b0;
      readdata = rd_phase ? slv_mem[o_addr[7:2]] : $urandom;
      if (read || write) begin
        if (o_strobes == 0) begin
          o_rd = read; o_wr = write; o_be = byteenable; o_addr = address; o_wd = writedata;
        end else if (read !== o_rd || write !== o_wr || byteenable !== o_be ||
                     address !== o_addr || writedata !== o_wd) begin
          o_unstable = 1'b1;
        end
        o_strobes++;
        waitrequest = stuck || (waits_left > 0);
        if (waits_left > 0) waits_left--;
        if (!waitrequest) begin
          if (write) begin
            for (int k = 0; k < 4; k++)
              if (byteenable[k]) slv_mem[address[7:2]][8*k +: 8] = writedata[8*k +: 8];
          end else begin
            rd_next = 1'b1;
          end
        end
      end else begin
        if (address !== 32'd0 || byteenable !== 4'd0 || writedata !== 32'd0) o_idle_dirty = 1'b1;
        waitrequest = 1'($urandom_range(0, 1));
      end
      if (resp_valid === 1'b1) begin
        o_lat = c; o_err = resp_err; o_rdata = resp_rdata; o_ready_at_resp = req_ready;
        break;
      end
      @(posedge clk); #1;
    end
    waitrequest = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL reset resp got v=%b e=%b want 0 0", resp_valid, resp_err); end
    vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset resp_rdata got %h want 0", resp_rdata); end
    vectors++; if (read !== 1'b0 || write !== 1'b0) begin miscompares++; $display("FAIL reset strobes got r=%b w=%b want 0 0", read, write); end
    vectors++; if (address !== 32'd0 || byteenable !== 4'd0 || writedata !== 32'd0) begin
      miscompares++; $display("FAIL reset bus got a=%h be=%b wd=%h want 0", address, byteenable, writedata); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    clear_mem();
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    vectors++; if (o_wr !== 1'b1 || o_addr !== 32'h10 || o_be !== 4'b1111 || o_wd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL word_store bus got w=%b a=%h be=%b wd=%h want 1 10 1111 deadbeef", o_wr, o_addr, o_be, o_wd); end
    vectors++; if (o_lat !== 2 || o_err !== 1'b0) begin miscompares++; $display("FAIL word_store resp got lat=%0d err=%b want 2 0", o_lat, o_err); end

    slv_mem[4] = 32'h80FF_0000;
    run_txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0);
    vectors++; if (o_strobes !== 3 || o_rd !== 1'b1 || o_be !== 4'b1000) begin
      miscompares++; $display("FAIL sbyte_load bus got cycles=%0d r=%b be=%b want 3 1 1000", o_strobes, o_rd, o_be); end
    vectors++; if (o_lat !== 5 || o_rdata !== 32'hFFFF_FF80) begin
      miscompares++; $display("FAIL sbyte_load resp got lat=%0d data=%h want 5 ffffff80", o_lat, o_rdata); end
    run_txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    vectors++; if (o_rdata !== 32'h0000_0080) begin miscompares++; $display("FAIL ubyte_load got %h want 00000080", o_rdata); end

    run_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234, 0, 1'b0);
    vectors++; if (o_be !== 4'b1100 || o_wd !== 32'h1234_1234 || o_addr !== 32'h20) begin
      miscompares++; $display("FAIL half_store bus got be=%b wd=%h a=%h want 1100 12341234 20", o_be, o_wd, o_addr); end
    run_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0, 1'b0);
    vectors++; if (o_rdata !== 32'h0000_1234 || o_lat !== 3) begin
      miscompares++; $display("FAIL half_load got data=%h lat=%0d want 00001234 3", o_rdata, o_lat); end

    run_txn(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 1'b0);
    vectors++; if (o_strobes !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0000_1234) begin
      miscompares++; $display("FAIL misaligned_word got strobes=%0d lat=%0d err=%b data=%h want 0 1 1 00001234", o_strobes, o_lat, o_err, o_rdata); end
    run_txn(1'b1, 2'b11, 1'b0, 32'h40, 32'h5555_AAAA, 0, 1'b0);
    vectors++; if (o_strobes !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0000_1234) begin
      miscompares++; $display("FAIL illegal_size got strobes=%0d lat=%0d err=%b data=%h want 0 1 1 00001234", o_strobes, o_lat, o_err, o_rdata); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b1);
    vectors++; if (o_strobes !== 4 || o_lat !== 5 || o_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout got read_cycles=%0d lat=%0d err=%b want 4 5 1", o_strobes, o_lat, o_err); end
    vectors++; if (o_rdata !== 32'h0000_1234) begin miscompares++; $display("FAIL timeout_rdata got %h want 00001234", o_rdata); end
    run_txn(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1, 1'b0);
    vectors++; if (o_lat !== 4 || o_err !== 1'b0 || o_rdata !== 32'h0000_1234) begin
      miscompares++; $display("FAIL after_timeout got lat=%0d err=%b data=%h want 4 0 00001234", o_lat, o_err, o_rdata); end
  endtask

  task automatic test_random();
    logic        wr, sg, bad;
    logic [1:0]  sz;
    logic [31:0] wd, exp_wd, exp_hold;
    logic [3:0]  exp_be;
    int          a, nbytes, nwait, exp_lat;
    longint      v;
    clear_mem();
    exp_hold = 32'h0000_1234;  // last successful load of the earlier tests
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = $urandom_range(0, 255);
      wd = $urandom; nwait = $urandom_range(0, 3);
      bad    = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
      nbytes = 1 << sz;
      exp_be = 4'(((1 << nbytes) - 1) << (a % 4));
      exp_wd = (sz == 2'd0) ? wd[7:0] * 32'h0101_0101 : (sz == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
      exp_lat = bad ? 1 : (wr ? 2 + nwait : 3 + nwait);
      run_txn(wr, sz, sg, 32'(a), wd, nwait, 1'b0);
      if (!bad && wr)
        for (int k = 0; k < nbytes; k++) ref_mem[a + k] = wd[8*k +: 8];
      if (!bad && !wr) begin
        v = 0;
        for (int k = 0; k < nbytes; k++) v = v | (longint'(ref_mem[a + k]) << (8 * k));
        if (sg && nbytes < 4 && v[8*nbytes-1]) v = v - (longint'(1) << (8 * nbytes));
        exp_hold = v[31:0];
      end
      vectors++; if (o_lat !== exp_lat || o_err !== bad) begin
        miscompares++; $display("FAIL rand[%0d] resp got lat=%0d err=%b want %0d %b", i, o_lat, o_err, exp_lat, bad); end
      vectors++; if (o_rdata !== exp_hold) begin
        miscompares++; $display("FAIL rand[%0d] rdata got %h want %h", i, o_rdata, exp_hold); end
      vectors++; if (o_ready_at_resp !== 1'b0 || o_idle_dirty !== 1'b0 || o_unstable !== 1'b0) begin
        miscompares++; $display("FAIL rand[%0d] protocol got ready_at_resp=%b idle_dirty=%b unstable=%b want 0 0 0", i, o_ready_at_resp, o_idle_dirty, o_unstable); end
      if (bad) begin
        vectors++; if (o_strobes !== 0) begin miscompares++; $display("FAIL rand[%0d] reject_strobes got %0d want 0", i, o_strobes); end
      end else begin
        vectors++; if (o_strobes !== nwait + 1 || o_rd !== !wr || o_wr !== wr || o_be !== exp_be || o_addr !== 32'(a & ~3)) begin
          miscompares++; $display("FAIL rand[%0d] bus got n=%0d r=%b w=%b be=%b a=%h want %0d %b %b %b %h", i, o_strobes, o_rd, o_wr, o_be, o_addr, nwait + 1, !wr, wr, exp_be, a & ~3); end
        if (wr) begin
          vectors++; if (o_wd !== exp_wd) begin miscompares++; $display("FAIL rand[%0d] writedata got %h want %h", i, o_wd, exp_wd); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int got_resp;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    req_valid = 1'b0; waitrequest = 1'b1;
    vectors++; if (write !== 1'b1) begin miscompares++; $display("FAIL midreset_pre write got %b want 1", write); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (write !== 1'b0 || address !== 32'd0) begin
      miscompares++; $display("FAIL midreset_drop got w=%b a=%h want 0 0", write, address); end
    @(posedge clk); #1;
    reset_n = 1'b1; waitrequest = 1'b0;
    got_resp = 0;
    repeat (4) begin @(posedge clk); #1; if (resp_valid === 1'b1) got_resp++; end
    vectors++; if (got_resp !== 0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset_after got resp_pulses=%0d ready=%b want 0 1", got_resp, req_ready); end
    slv_mem[4] = 32'hCAFE_0001;
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    vectors++; if (o_lat !== 4 || o_err !== 1'b0 || o_rdata !== 32'hCAFE_0001) begin
      miscompares++; $display("FAIL midreset_load got lat=%0d err=%b data=%h want 4 0 cafe0001", o_lat, o_err, o_rdata); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
